integrate_fire: RTL and testbench
=================================

# integrate_fire

Leaky integrate-and-fire soma that produces the spike pulse `p_s` consumed by the downstream inhibit/refractory stage. Each valid timestep it sums the programmable synaptic weights of the active input spikes into a signed membrane potential, applies a shift-based leak, and fires a one-cycle pulse when the threshold is reached. After firing it holds off integration for a fixed refractory count and for as long as the downstream `Enable` (fed back as `inh_en`) is high.

## Interface
- `N_IN`, 4: number of synaptic inputs
- `W_WIDTH`, 8: signed weight width
- `ACC_WIDTH`, 16: signed membrane potential width
- `THRESHOLD`, 100: fire level (signed, ACC_WIDTH bits)
- `LEAK_SHIFT`, 3: leak = v >>> LEAK_SHIFT per timestep
- `REFRACT_CYC`, 4: refractory cycles after the fire cycle (≥1)
- `Clk` in 1: the block's single clock; all logic on posedge
- `Rst` in 1: reset, synchronous and active-high
- `in_valid` in 1: timestep strobe; `in_spikes` is sampled when `in_valid & in_ready`
- `in_spikes` in N_IN: active-high spike per synapse
- `in_ready` out 1: `state==INTEG && !inh_en`
- `w_we` in 1: weight write enable
- `w_addr` in clog2(N_IN): weight index
- `w_data` in W_WIDTH: signed weight value
- `inh_en` in 1: inhibit from the downstream stage's `Enable`
- `p_s` out 1: registered spike pulse, exactly one cycle wide
- `v_mem` out ACC_WIDTH: current membrane potential (signed)

## Operation
- States: INTEG, FIRE, REFRACT. Reset → INTEG, `v_mem`=0, `p_s`=0, all weights 0, refractory counter 0.
- INTEG, accepted timestep: `sum` = Σ w[i] over set `in_spikes[i]`, computed at ACC_WIDTH+clog2(N_IN)+1 bits; `v_next` = v − (v >>> LEAK_SHIFT) + sum; saturate to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. If `v_next ≥ THRESHOLD` → FIRE, else `v_mem` ← `v_next`.
- INTEG, no accepted timestep: `v_mem` holds. No leak.
- FIRE: lasts one cycle; `p_s`=1; `v_mem` ← 0; counter ← 0; → REFRACT.
- REFRACT: inputs dropped; counter increments each cycle. When the counter reaches REFRACT_CYC and `inh_en`=0, go to INTEG. With `inh_en`=1, stay in REFRACT with the counter saturated.
- `inh_en`=1 in INTEG: `in_ready`=0 and `v_mem` holds.
- Weight writes are allowed in any state and take effect the following cycle. A timestep accepted in the same cycle as a write uses the old weight.
- `Rst` mid-operation, including during FIRE: everything returns to reset values next cycle. A pending `p_s` is suppressed.
- Leak uses an arithmetic shift, so negative values round toward −∞.

## Timing
- Timestep crossing the threshold accepted at cycle t: FIRE and `p_s`=1 at t+1, `v_mem`=0 from t+1.
- REFRACT covers t+2 … t+1+REFRACT_CYC. The earliest `in_ready`=1 is t+2+REFRACT_CYC if `inh_en`=0.
- `in_ready` and `v_mem` are registered or derived from registered state only. There is no combinational path from `in_spikes` to any output.

## Configuration
- `NEURON_LEAK_EN` defined: leak term applied as above.
- `NEURON_LEAK_EN` undefined: pure integrator, `v_next` = v + sum. `LEAK_SHIFT` is unused. Saturation is unchanged.

## Structure
- Package `neuron_pkg`: state enum (INTEG/FIRE/REFRACT), saturating-add function, default width constants.
- Sub-module `weighted_sum`: holds the weight register file and the masked adder, and outputs `sum`. The FSM, leak, saturation and refractory counter stay in `integrate_fire`.

## Test plan
All tests use defaults: weights 40, 30, 20, −50 at addresses 0..3.
- Reset check: `Rst` for 2 cycles → `p_s`=0, `v_mem`=0, `in_ready`=1, all weights read as 0 (spikes 4'b1111 leave `v_mem`=0).
- Fire with leak: spikes 4'b0011 twice → `v_mem`=70, then 70−8+70=132 ≥ 100. `p_s`=1 for exactly one cycle, after which `v_mem`=0.
- Refractory: `in_valid` held high through the fire → `in_ready`=0 for 5 cycles (FIRE + 4). Spikes in that window do not change `v_mem`.
- Inhibit hold: `inh_en`=1 from the fire until 10 cycles later → state stays REFRACT. `in_ready` returns to 1 the cycle after `inh_en` falls.
- Saturation, built without `NEURON_LEAK_EN`: all weights −128, spikes 4'b1111 for 70 timesteps → `v_mem` reaches −32768 at step 64 and stays there, with no wrap and no fire.
- Write collision: write w[0]=100 in the same cycle as a timestep with spikes 4'b0001 → `v_mem`=40 (old weight). The next identical timestep yields 40−5+100=135 → fire.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the integrate-and-fire soma.
// Holds the FSM state enum, default widths and a saturating add.
package neuron_pkg;

  localparam int N_IN_D      = 4;
  localparam int W_WIDTH_D   = 8;
  localparam int ACC_WIDTH_D = 16;

  typedef enum logic [1:0] {
    INTEG,
    FIRE,
    REFRACT
  } state_t;

  // Adds two signed values and clips to a w-bit signed range.
  // Operands are sign-extended to 33 bits so the add cannot wrap.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    if (s > hi) begin
      return hi[31:0];
    end else if (s < lo) begin
      return lo[31:0];
    end else begin
      return s[31:0];
    end
  endfunction

endpackage

// File: rtl/integrate_fire_if.sv
// Handshake, weight-write and status bundle of integrate_fire.
// master: drives timesteps, weight writes, inh_en; slave: the soma.
interface integrate_fire_if #(
  parameter int N_IN      = 4,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16
) ();

  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                        in_valid;
  logic [N_IN-1:0]             in_spikes;
  logic                        in_ready;
  logic                        w_we;
  logic [AW-1:0]               w_addr;
  logic signed [W_WIDTH-1:0]   w_data;
  logic                        inh_en;
  logic                        p_s;
  logic signed [ACC_WIDTH-1:0] v_mem;

  modport master (
    output in_valid, in_spikes,
    output w_we, w_addr, w_data,
    output inh_en,
    input  in_ready, p_s, v_mem
  );

  modport slave (
    input  in_valid, in_spikes,
    input  w_we, w_addr, w_data,
    input  inh_en,
    output in_ready, p_s, v_mem
  );

endinterface

// File: rtl/weighted_sum.sv
// Synaptic weight register file plus masked adder.
// Ports: Clk, Rst, w_we/w_addr/w_data write, spikes mask, sum out.
module weighted_sum #(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = 8,
  parameter int SW      = 19,
  parameter int AW      = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      w_we,
  input  logic [AW-1:0]             w_addr,
  input  logic signed [W_WIDTH-1:0] w_data,
  input  logic [N_IN-1:0]           spikes,
  output logic signed [SW-1:0]      sum
);

  logic signed [W_WIDTH-1:0] w_q [N_IN];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= '0;
      end
    end else if (w_we) begin
      w_q[w_addr] <= w_data;
    end
  end

  // Reads the registered weights, so a same-cycle write is not seen.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spikes[i]) begin
        sum = sum + SW'(w_q[i]);
      end
    end
  end

endmodule

// File: rtl/integrate_fire.sv
// Leaky integrate-and-fire soma: INTEG/FIRE/REFRACT with saturation.
// Ports: Clk, Rst, bus (slave). Leak enabled by NEURON_LEAK_EN.
module integrate_fire
  import neuron_pkg::*;
#(
  parameter int N_IN        = N_IN_D,
  parameter int W_WIDTH     = W_WIDTH_D,
  parameter int ACC_WIDTH   = ACC_WIDTH_D,
  parameter logic signed [ACC_WIDTH-1:0] THRESHOLD = 100,
  parameter int LEAK_SHIFT  = 3,
  parameter int REFRACT_CYC = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  integrate_fire_if.slave bus
);

  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SW = ACC_WIDTH + $clog2(N_IN) + 1;
  localparam int CW = $clog2(REFRACT_CYC + 1);
  localparam logic [CW-1:0] RC = CW'(REFRACT_CYC);

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] v_q, v_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [CW-1:0]               cnt_inc;

  logic signed [SW-1:0]        sum;
  logic signed [SW-1:0]        v_ext;
  logic signed [SW-1:0]        base;
  logic signed [31:0]          v_sat;
  logic signed [ACC_WIDTH-1:0] v_next;
  logic                        accept;

  weighted_sum #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH),
    .SW      (SW),
    .AW      (AW)
  ) u_ws (
    .Clk    (Clk),
    .Rst    (Rst),
    .w_we   (bus.w_we),
    .w_addr (bus.w_addr),
    .w_data (bus.w_data),
    .spikes (bus.in_spikes),
    .sum    (sum)
  );

  assign v_ext = SW'(v_q);

`ifdef NEURON_LEAK_EN
  // Arithmetic shift: negative potentials leak toward -inf.
  assign base = v_ext - (v_ext >>> LEAK_SHIFT);
`else
  logic unused_leak;
  assign unused_leak = |LEAK_SHIFT;
  assign base = v_ext;
`endif

  assign v_sat  = sat_add(32'(base), 32'(sum), ACC_WIDTH);
  assign v_next = ACC_WIDTH'(v_sat);

  assign bus.in_ready = (state_q == INTEG) && !bus.inh_en;
  assign bus.p_s      = (state_q == FIRE);
  assign bus.v_mem    = v_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign cnt_inc = (cnt_q == RC) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= INTEG;
      v_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INTEG: begin
        if (accept) begin
          if (v_next >= THRESHOLD) begin
            // Potential clears on the crossing edge, so it reads 0 in FIRE.
            state_d = FIRE;
            v_d     = '0;
            cnt_d   = '0;
          end else begin
            v_d = v_next;
          end
        end
      end
      FIRE: begin
        v_d     = '0;
        cnt_d   = '0;
        state_d = REFRACT;
      end
      REFRACT: begin
        cnt_d = cnt_inc;
        if (cnt_inc == RC && !bus.inh_en) begin
          state_d = INTEG;
        end
      end
      default: begin
        state_d = INTEG;
      end
    endcase
  end

endmodule

// File: tb/tb_integrate_fire.sv
// Scoreboard bench for integrate_fire: directed vectors queue
// expected outputs; a negedge monitor pops and compares them.
module tb_integrate_fire;

`ifdef NEURON_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif

  typedef struct packed {
    logic [8*8-1:0]     tag;
    logic signed [15:0] v;
    logic               r;
    logic               p;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  integrate_fire_if #(.N_IN(4), .W_WIDTH(8), .ACC_WIDTH(16)) bus ();

  integrate_fire #(
    .N_IN        (4),
    .W_WIDTH     (8),
    .ACC_WIDTH   (16),
    .THRESHOLD   (16'sd100),
    .LEAK_SHIFT  (3),
    .REFRACT_CYC (4)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      if (bus.v_mem === e.v) n_pass++;
      else $display("FAIL %0s v_mem got %0d want %0d",
                    e.tag, bus.v_mem, e.v);
      n_total++;
      if (bus.in_ready === e.r) n_pass++;
      else $display("FAIL %0s in_ready got %b want %b",
                    e.tag, bus.in_ready, e.r);
      n_total++;
      if (bus.p_s === e.p) n_pass++;
      else $display("FAIL %0s p_s got %b want %b",
                    e.tag, bus.p_s, e.p);
    end
  end

  task automatic tick(
    input logic              r_,
    input logic              vld,
    input logic [3:0]        spk,
    input logic              inh,
    input logic              we,
    input logic [1:0]        wa,
    input logic signed [7:0] wd,
    input bit                chk,
    input logic [8*8-1:0]    tag,
    input int                ev,
    input logic              er,
    input logic              ep
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r_;
    bus.in_valid  = vld;
    bus.in_spikes = spk;
    bus.inh_en    = inh;
    bus.w_we      = we;
    bus.w_addr    = wa;
    bus.w_data    = wd;
    if (chk) begin
      e.tag = tag;
      e.v   = 16'(ev);
      e.r   = er;
      e.p   = ep;
      q.push_back(e);
    end
  endtask

  task automatic ts(
    input logic [8*8-1:0] tag,
    input logic           vld,
    input logic [3:0]     spk,
    input logic           inh,
    input int             ev,
    input logic           er,
    input logic           ep
  );
    tick(1'b0, vld, spk, inh, 1'b0, 2'd0, 8'sd0,
         1'b1, tag, ev, er, ep);
  endtask

  task automatic tw(
    input logic [8*8-1:0]    tag,
    input logic              vld,
    input logic [3:0]        spk,
    input logic [1:0]        wa,
    input logic signed [7:0] wd,
    input int                ev
  );
    tick(1'b0, vld, spk, 1'b0, 1'b1, wa, wd,
         1'b1, tag, ev, 1'b1, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_spikes = '0;
    bus.inh_en    = 1'b0;
    bus.w_we      = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    repeat (2) @(posedge clk);

    ts("rst", 1, 4'b1111, 0, 0, 1, 0);
    ts("w0sum", 0, 4'b0000, 0, 0, 1, 0);
    tw("wr0", 0, 4'b0000, 2'd0, 8'sd40, 0);
    tw("wr1", 0, 4'b0000, 2'd1, 8'sd30, 0);
    tw("wr2", 0, 4'b0000, 2'd2, 8'sd20, 0);
    tw("wr3", 0, 4'b0000, 2'd3, -8'sd50, 0);

    ts("acc1", 1, 4'b0011, 0, 0, 1, 0);
    ts("acc2", 1, 4'b0011, 0, 70, 1, 0);
    ts("fire", 1, 4'b1111, 0, 0, 0, 1);
    repeat (4) ts("refr", 1, 4'b0001, 0, 0, 0, 0);
    ts("rdy", 0, 4'b0000, 0, 0, 1, 0);

    ts("inhi", 1, 4'b0011, 1, 0, 0, 0);
    ts("inhr", 0, 4'b0000, 0, 0, 1, 0);

    ts("iacc1", 1, 4'b0011, 0, 0, 1, 0);
    ts("iacc2", 1, 4'b0011, 0, 70, 1, 0);
    ts("ifire", 0, 4'b0000, 1, 0, 0, 1);
    repeat (9) ts("ihold", 1, 4'b1111, 1, 0, 0, 0);
    ts("ifall", 0, 4'b0000, 0, 0, 0, 0);
    ts("irdy", 0, 4'b0000, 0, 0, 1, 0);

    tw("coll", 1, 4'b0001, 2'd0, 8'sd100, 0);
    ts("old", 1, 4'b0001, 0, 40, 1, 0);
    ts("cfire", 0, 4'b0000, 0, 0, 0, 1);
    repeat (4) ts("crefr", 0, 4'b0000, 0, 0, 0, 0);
    ts("crdy", 0, 4'b0000, 0, 0, 1, 0);

    ts("eq", 1, 4'b0001, 0, 0, 1, 0);
    tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'sd0,
         1'b1, "eqfire", 0, 1'b0, 1'b1);
    ts("rstf", 0, 4'b0000, 0, 0, 1, 0);
    tw("wcl", 1, 4'b1000, 2'd3, -8'sd50, 0);
    ts("w3z", 1, 4'b1000, 0, 0, 1, 0);
    ts("neg", 1, 4'b0000, 0, -50, 1, 0);
    ts("leak", 0, 4'b0000, 0, LEAK ? -43 : -50, 1, 0);

    if (!LEAK) begin
      tick(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'sd0,
           1'b0, "srst", 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        tw("sw", 0, 4'b0000, 2'(i), -8'sd128, 0);
      end
      for (int i = 0; i < 70; i++) begin
        ts("sat", 1, 4'b1111, 0,
           (-512 * i < -32768) ? -32768 : -512 * i, 1, 0);
      end
      ts("satend", 0, 4'b0000, 0, -32768, 1, 0);
    end

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
